// File: rtl/div_arb_pkg.sv
// Shared types and constants for the divider arbiter: FSM states, response
// error codes and the fixed result returned for a zero divisor.
package div_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    CLEAR,
    RUN,
    RESP
  } state_t;

  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_DIV0    = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

  localparam logic [31:0] DIV0_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] grant,
  output logic          any_req
);

  logic [PW:0] idx;

  always_comb begin
    grant   = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      // One extra bit so ptr+i never overflows before the modulo-N fold.
      idx = {1'b0, ptr} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!any_req && req[idx[PW-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one 16/16 divider core among N requesters: round-robin grant,
// operand latch, init pulse, stale-done discard, zero-divisor bypass, timeout.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 256,
  parameter int TW      = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [16*N-1:0] op_a,
  input  logic [16*N-1:0] op_b,
  output logic [N-1:0]    rsp_valid,
  output logic [31:0]     rsp_result,
  output logic [1:0]      rsp_err,
  output logic            busy,
  output logic            div_init,
  output logic [15:0]     div_a,
  output logic [15:0]     div_b,
  input  logic [31:0]     div_result,
  input  logic            div_done
);

  localparam int            PW      = (N > 1) ? $clog2(N) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_q;
  logic [TW-1:0] tcnt;
  logic [PW-1:0] arb_grant;
  logic          arb_any;
  logic [15:0]   win_a;
  logic [15:0]   win_b;

  rr_arbiter #(.N(N), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .grant   (arb_grant),
    .any_req (arb_any)
  );

  assign win_a = op_a[{arb_grant, 4'b0000} +: 16];
  assign win_b = op_b[{arb_grant, 4'b0000} +: 16];

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] g);
    logic [PW:0] s;
    s = {1'b0, g} + (PW+1)'(1);
    if (s >= (PW+1)'(N)) s = '0;
    return s[PW-1:0];
  endfunction

  function automatic logic [N-1:0] onehot(input logic [PW-1:0] g);
    return N'(1) << g;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_q    <= '0;
      tcnt       <= '0;
      busy       <= 1'b0;
      div_init   <= 1'b0;
      div_a      <= '0;
      div_b      <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_err    <= ERR_OK;
    end else begin
      div_init  <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            grant_q <= arb_grant;
            ptr     <= wrap_inc(arb_grant);
            div_a   <= win_a;
            div_b   <= win_b;
            busy    <= 1'b1;
            // A zero divisor never reaches the core.
            if (win_b == '0) begin
              state      <= RESP;
              rsp_valid  <= onehot(arb_grant);
              rsp_result <= DIV0_RESULT;
              rsp_err    <= ERR_DIV0;
            end else begin
              state    <= ISSUE;
              div_init <= 1'b1;
            end
          end
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= CLEAR;
        end
        CLEAR: begin
          // A done still high here belongs to the previous job.
          if (tcnt == TO_LAST) begin
            state      <= RESP;
            rsp_valid  <= onehot(grant_q);
            rsp_result <= '0;
            rsp_err    <= ERR_TIMEOUT;
          end else begin
            tcnt <= tcnt + TW'(1);
            if (!div_done) state <= RUN;
          end
        end
        RUN: begin
          if (div_done) begin
            state      <= RESP;
            rsp_valid  <= onehot(grant_q);
            rsp_result <= div_result;
            rsp_err    <= ERR_OK;
          end else if (tcnt == TO_LAST) begin
            state      <= RESP;
            rsp_valid  <= onehot(grant_q);
            rsp_result <= '0;
            rsp_err    <= ERR_TIMEOUT;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider core, transaction-level
// round-robin/result model checked every cycle, plus directed scenarios.
module tb_div_arbiter;

  localparam int N       = 4;
  localparam int IW      = $clog2(N);
  localparam int TIMEOUT = 256;
  localparam int L       = 16;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req = '0;
  logic [16*N-1:0] op_a;
  logic [16*N-1:0] op_b;
  logic [N-1:0]    rsp_valid;
  logic [31:0]     rsp_result;
  logic [1:0]      rsp_err;
  logic            busy;
  logic            div_init;
  logic [15:0]     div_a;
  logic [15:0]     div_b;
  logic [31:0]     div_result;
  logic            div_done;

  logic [15:0] a_m [N] = '{default: '0};
  logic [15:0] b_m [N] = '{default: '0};

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < N; i++) begin
      op_a[16*i +: 16] = a_m[i];
      op_b[16*i +: 16] = b_m[i];
    end
  end

  div_arbiter #(.N(N), .TIMEOUT(TIMEOUT), .TW(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy),
    .div_init   (div_init),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_result (div_result),
    .div_done   (div_done)
  );

  // Divider core: done rises L cycles after init. hang: never completes.
  // stale: the previous done stays high for 3 cycles after init.
  logic        hang = 1'b0;
  logic        stale = 1'b0;
  logic        core_done;
  logic [31:0] core_res;
  logic [31:0] res_next;
  logic        active;
  logic        job_hang;
  int          lat_left;
  int          stale_left;

  assign div_done   = core_done;
  assign div_result = core_res;

  always @(posedge clk) begin
    if (reset) begin
      core_done  <= 1'b0;
      core_res   <= '0;
      res_next   <= '0;
      active     <= 1'b0;
      job_hang   <= 1'b0;
      lat_left   <= 0;
      stale_left <= 0;
    end else if (div_init) begin
      active     <= 1'b1;
      job_hang   <= hang;
      lat_left   <= L - 1;
      stale_left <= stale ? 3 : 0;
      if (!stale) core_done <= 1'b0;
      res_next   <= (div_b == 16'd0) ? 32'd0 : {16'(div_a % div_b), 16'(div_a / div_b)};
    end else if (active && !job_hang) begin
      if (stale_left > 0) begin
        stale_left <= stale_left - 1;
        if (stale_left == 1) core_done <= 1'b0;
      end
      if (lat_left > 0) lat_left <= lat_left - 1;
      else if (stale_left == 0) begin
        core_done <= 1'b1;
        core_res  <= res_next;
        active    <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Model: winner is the first pending request at or after the model pointer.
  function automatic int pick(input logic [N-1:0] r, input int p);
    logic [IW-1:0] j;
    for (int k = 0; k < N; k++) begin
      j = IW'((p + k) % N);
      if (r[j]) return (p + k) % N;
    end
    return -1;
  endfunction

  int          ptr_m = 0;
  int          exp_inits = 0;
  int          inits_seen = 0;
  int          rsp_count = 0;
  int          last_idx = -1;
  int          last_cyc = 0;
  logic [31:0] last_res = '0;
  logic [1:0]  last_err = '0;
  int          grant_log[$];

  initial begin
    int          w;
    logic [31:0] er;
    logic [1:0]  ee;
    forever begin
      @(negedge clk);
      if (reset) begin
        ptr_m      = 0;
        exp_inits  = 0;
        inits_seen = 0;
        last_res   = '0;
        last_err   = '0;
      end else begin
        if (div_init) inits_seen++;
        if (rsp_valid != '0) begin
          w = pick(req, ptr_m);
          if (w < 0) begin
            chk("rsp_spurious", 32'(rsp_valid), 32'd0);
          end else begin
            if (b_m[w] == 16'd0) begin
              er = 32'hFFFF_FFFF; ee = 2'b01;
            end else if (hang) begin
              er = 32'd0; ee = 2'b10; exp_inits++;
            end else begin
              er = {16'(a_m[w] % b_m[w]), 16'(a_m[w] / b_m[w])}; ee = 2'b00; exp_inits++;
            end
            chk("rsp_who", 32'(rsp_valid), 32'(1) << w);
            chk("rsp_result", rsp_result, er);
            chk("rsp_err", 32'(rsp_err), 32'(ee));
            chk("rsp_busy", 32'(busy), 32'd1);
            chk("init_count", 32'(inits_seen), 32'(exp_inits));
            ptr_m = (w + 1) % N;
            last_idx = w;
            grant_log.push_back(w);
          end
          last_res = rsp_result;
          last_err = rsp_err;
          last_cyc = cyc;
          rsp_count++;
        end else begin
          chk("hold_result", rsp_result, last_res);
          chk("hold_err", 32'(rsp_err), 32'(last_err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    int n;
    n = 0;
    while (rsp_count < target && n < budget) begin
      tick();
      n++;
    end
    chk("wait_rsp", 32'(rsp_count >= target), 32'd1);
  endtask

  // lat: cycle of the response minus the cycle in which req was raised.
  task automatic run_job(input int i, input logic [15:0] a, input logic [15:0] b, input int lat,
                         input logic [31:0] er, input logic [1:0] ee, input string nm);
    int c0;
    int tgt;
    a_m[i] = a;
    b_m[i] = b;
    c0  = cyc;
    tgt = rsp_count + 1;
    req[IW'(i)] = 1'b1;
    wait_rsp(tgt, 400);
    req[IW'(i)] = 1'b0;
    chk({nm, "_idx"}, 32'(last_idx), 32'(i));
    chk({nm, "_lat"}, 32'(last_cyc - c0), 32'(lat));
    chk({nm, "_res"}, last_res, er);
    chk({nm, "_err"}, 32'(last_err), 32'(ee));
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int jobs[N];
    int handled;
    int n;
    int c0;
    int n0;
    int g;

    reset = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init", 32'(div_init), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_result", rsp_result, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_div_a", 32'(div_a), 32'd0);
    chk("rst_div_b", 32'(div_b), 32'd0);
    reset = 1'b0;
    tick();

    // 100/7: quotient 14, remainder 2; IDLE+ISSUE+CLEAR+16 RUN+RESP.
    run_job(0, 16'd100, 16'd7, L + 3, 32'h0002_000E, 2'b00, "single");

    do_reset();
    for (int i = 0; i < N; i++) begin
      a_m[i] = 16'(10 * (i + 1));
      b_m[i] = 16'd3;
    end
    jobs = '{2, 1, 1, 1};
    grant_log.delete();
    handled = 0;
    n = 0;
    req = 4'b1111;
    while (handled < 5 && n < 500) begin
      tick();
      n++;
      while (handled < grant_log.size()) begin
        g = grant_log[handled];
        handled++;
        jobs[g]--;
        if (jobs[g] <= 0) req[IW'(g)] = 1'b0;
      end
    end
    chk("rr_count", 32'(handled), 32'd5);
    for (int k = 0; k < 5; k++)
      if (k < grant_log.size()) chk("rr_order", 32'(grant_log[k]), 32'(exp_order[k]));
    chk("rr_last_res", last_res, 32'h0001_0003);

    // Zero divisor: IDLE cycle then RESP, no init.
    n0 = inits_seen;
    run_job(2, 16'd5, 16'd0, 1, 32'hFFFF_FFFF, 2'b01, "div0");
    chk("div0_no_init", 32'(inits_seen), 32'(n0));

    // Hung core: ISSUE plus TIMEOUT cycles in CLEAR/RUN, then RESP.
    hang = 1'b1;
    run_job(3, 16'd9, 16'd2, TIMEOUT + 2, 32'd0, 2'b10, "timeout");
    hang = 1'b0;
    run_job(3, 16'd9, 16'd2, L + 3, 32'h0001_0004, 2'b00, "after_to");

    // Previous done still high for 3 cycles after init.
    stale = 1'b1;
    chk("stale_pre_done", 32'(div_done), 32'd1);
    run_job(1, 16'd50, 16'd6, L + 3, 32'h0002_0008, 2'b00, "stale");
    stale = 1'b0;

    // Reset while the core is running.
    a_m[0] = 16'd100;
    b_m[0] = 16'd7;
    c0 = cyc;
    req[0] = 1'b1;
    n = 0;
    while (cyc < c0 + 5 && n < 20) begin
      tick();
      n++;
    end
    chk("run_busy", 32'(busy), 32'd1);
    n0 = rsp_count;
    reset = 1'b1;
    req = '0;
    tick();
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_init", 32'(div_init), 32'd0);
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    repeat (30) tick();
    chk("mid_rst_no_rsp", 32'(rsp_count), 32'(n0));
    run_job(1, 16'd40, 16'd5, L + 3, 32'h0000_0008, 2'b00, "post_rst");

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
- Shares one divider core (16-bit operands, 32-bit result, init/done handshake) among N requesters on the J1 SoC.
- Grants access round-robin, latches the winner's operands and pulses the core's init. It then waits for done and returns the result to the granted requester.
- Short-circuits divide-by-zero and recovers from a hung core via a timeout.
- Sits between the requester blocks (CPU peripheral slot, accelerators) and the single divider instance.

Parameters:
- N, 4, number of requesters (2..8).
- TIMEOUT, 256, max cycles waiting for div_done before aborting.
- TW, 9, timeout counter width; must satisfy 2**TW > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  N  per-requester request level.
- op_a  in  16*N  dividends; requester i uses bits [16i+15:16i].
- op_b  in  16*N  divisors; same packing as op_a.
- rsp_valid  out  N  one-cycle one-hot pulse: response for requester i.
- rsp_result  out  32  result, valid while rsp_valid != 0.
- rsp_err  out  2  00 ok, 01 divide-by-zero, 10 timeout.
- busy  out  1  high in every state except IDLE.
- div_init  out  1  start pulse to the divider core.
- div_a  out  16  latched dividend to the core.
- div_b  out  16  latched divisor to the core.
- div_result  in  32  core result; passed through unmodified.
- div_done  in  1  core done level; stays high until the next init.

Behaviour:
- Reset values:
  - all outputs 0; state IDLE.
  - rr pointer 0; timeout counter 0; grant register 0.
- Requester contract:
  - assert req[i] with operands stable until rsp_valid[i]; req may stay high to queue another job.
  - dropping req before the response is not allowed; the arbiter completes the job regardless.
- States: IDLE, ISSUE, CLEAR, RUN, RESP.
- IDLE (req != 0 at edge k):
  - pick the first set req at or after the pointer, wrapping modulo N.
  - register the grant index; latch div_a/div_b from that slot.
  - pointer <= grant+1 mod N.
  - if op_b of the winner == 0: go to RESP with err=01, result=32'hFFFF_FFFF; div_init is never asserted.
  - otherwise go to ISSUE.
- ISSUE:
  - div_init=1 for exactly this one cycle.
  - clear the timeout counter; go to CLEAR.
- CLEAR:
  - wait for div_done=0, which discards a stale done from the previous job.
  - if div_done is already 0 on entry, move to RUN on the next edge.
- RUN:
  - on div_done=1: capture div_result, err=00, go to RESP.
- Timeout:
  - the counter increments in CLEAR and RUN.
  - when count == TIMEOUT-1 without completion: result=0, err=10, go to RESP.
- RESP:
  - rsp_valid[grant]=1 for one cycle, with rsp_result/rsp_err valid.
  - go to IDLE; the next arbitration happens in the IDLE cycle that follows.
- Outside RESP, rsp_valid=0 and rsp_result/rsp_err hold their last value.
- Latency:
  - nominal: 4 + core cycles from a req sampled in IDLE to rsp_valid (IDLE, ISSUE, CLEAR, RUN×core, RESP).
  - divide-by-zero: rsp_valid 2 cycles after the sample edge.
- Fairness: any continuously asserted req is granted within N jobs.
- Simultaneous events:
  - a new req arriving during RESP waits for IDLE.
  - div_done and timeout in the same RUN cycle: done wins, err=00.
- Reset mid-operation:
  - returns to IDLE next edge; no rsp_valid for the aborted job.
  - div_init low; the core is reset by the same reset.
- div_a/div_b are held constant from latch until the next grant.

Decomposition:
- Package div_arb_pkg:
  - state enum (IDLE, ISSUE, CLEAR, RUN, RESP).
  - error codes ERR_OK, ERR_DIV0, ERR_TIMEOUT.
  - constant DIV0_RESULT = 32'hFFFF_FFFF.
- Sub-module rr_arbiter:
  - parameterised N; inputs req and pointer.
  - outputs grant index and any_req; purely combinational priority rotate.
  - pointer register lives in div_arbiter.

Test Plan:
- Single req[0], A=100, B=7; model core gives {rem,quot} after 16 cycles → div_init pulses once; rsp_valid=4'b0001, rsp_result=32'h0002_000E, err=00.
- req=4'b1111 held, all B=3 → grants in order 0,1,2,3,0; each rsp_valid one-hot; no requester serviced twice before the others.
- req[2] with B=0 → no div_init; rsp_valid[2] exactly 2 cycles after the sample edge; result FFFF_FFFF; err=01.
- Core that never asserts done, TIMEOUT=256 → rsp_valid after ISSUE+256 cycles; result 0, err=10; the next request is then served normally.
- Stale done (core keeps done=1 from the previous job for 3 cycles after init) → arbiter stays in CLEAR and captures only the new result.
- Reset asserted in RUN → next cycle busy=0, div_init=0, no rsp_valid; a subsequent req[1] is granted first (pointer=0, only req[1] set).
